// File: rtl/register_file_mp.sv
// Two-read / two-write register file with PC read override and a per-register load scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle writes to the read ports.
module register_file_mp #(
  parameter int DATA_W    = 32,
  parameter int NREGS     = 16,
  parameter int ADDR_W    = 4,
  parameter int PC_REG    = 15,
  parameter int PC_OFFSET = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] A1,
  input  logic [ADDR_W-1:0] A2,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  input  logic [ADDR_W-1:0] A3,
  input  logic [DATA_W-1:0] WD3,
  input  logic              WE3,
  input  logic [ADDR_W-1:0] A4,
  input  logic [DATA_W-1:0] WD4,
  input  logic              WE4,
  input  logic [DATA_W-1:0] R15,
  input  logic              SB_SET,
  input  logic [ADDR_W-1:0] SB_A,
  output logic              BUSY1,
  output logic              BUSY2,
  output logic              STALL,
  output logic              COLLIDE
);

  localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(PC_REG);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [NREGS-1:0]  pending_q;
  logic [DATA_W-1:0] pc_value;
  logic              collide_reg;

  assign pc_value = R15 + DATA_W'(PC_OFFSET);

  // One storage element and one pending bit per architectural register.
  for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
    localparam logic [ADDR_W-1:0] IDX = ADDR_W'(gi);
    localparam bit WRITABLE = (gi != PC_REG);

    logic [DATA_W-1:0] value_reg;
    logic              pending_reg;

    always_ff @(posedge clk) begin
      if (rst) begin
        value_reg <= '0;
      end else if (WRITABLE) begin
        // ALU port wins a same-address collision.
        if (WE3 && (A3 == IDX)) begin
          value_reg <= WD3;
        end else if (WE4 && (A4 == IDX)) begin
          value_reg <= WD4;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        pending_reg <= 1'b0;
      end else if (WRITABLE && SB_SET && (SB_A == IDX)) begin
        pending_reg <= 1'b1;
      end else if (WE4 && (A4 == IDX)) begin
        pending_reg <= 1'b0;
      end
    end

    assign regs_q[gi]    = value_reg;
    assign pending_q[gi] = pending_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      collide_reg <= 1'b0;
    end else begin
      collide_reg <= WE3 && WE4 && (A3 == A4);
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] rd_data;
    logic              busy;

    assign addr = (gi == 0) ? A1 : A2;

    always_comb begin
      rd_data = '0;
      busy    = 1'b0;
      for (int i = 0; i < NREGS; i++) begin
        if (addr == ADDR_W'(i)) begin
          rd_data = regs_q[i];
          busy    = pending_q[i];
        end
      end
`ifdef REGFILE_BYPASS_EN
      if ((addr != PC_ADDR) && ({1'b0, addr} < (ADDR_W + 1)'(NREGS))) begin
        if (WE3 && (A3 == addr)) begin
          rd_data = WD3;
        end else if (WE4 && (A4 == addr)) begin
          rd_data = WD4;
        end
        // A load landing this cycle is already forwarded, so its consumer need not wait.
        if (WE4 && (A4 == addr)) begin
          busy = 1'b0;
        end
      end
`endif
      if (addr == PC_ADDR) begin
        rd_data = pc_value;
        busy    = 1'b0;
      end
    end
  end

  assign RD1     = g_rd[0].rd_data;
  assign RD2     = g_rd[1].rd_data;
  assign BUSY1   = g_rd[0].busy;
  assign BUSY2   = g_rd[1].busy;
  assign STALL   = g_rd[0].busy | g_rd[1].busy;
  assign COLLIDE = collide_reg;

endmodule

// File: doc/register_file_mp.md
Name: register_file_mp

Overview:
- Parametrised successor to the single-write-port ARM-style register file.
- Provides two asynchronous read ports and two synchronous write ports: port 3 for ALU writeback, port 4 for load/long-latency writeback.
- PC-register read override returns the PC plus an offset.
- Per-register pending scoreboard drives decode-stage stall logic.
- Sits between decode (reads, scoreboard set) and writeback (writes, scoreboard clear).

Parameters:
- DATA_W, 32, register and data width in bits.
- NREGS, 16, number of architectural registers.
- ADDR_W, 4, register address width; NREGS must be at most 2**ADDR_W.
- PC_REG, 15, index whose reads return PC plus PC_OFFSET.
- PC_OFFSET, 8, constant added to R15 on a PC_REG read.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- A1  in  ADDR_W  read address, port 1.
- A2  in  ADDR_W  read address, port 2.
- RD1  out  DATA_W  read data, port 1.
- RD2  out  DATA_W  read data, port 2.
- A3  in  ADDR_W  write address, ALU port.
- WD3  in  DATA_W  write data, ALU port.
- WE3  in  1  write enable, ALU port.
- A4  in  ADDR_W  write address, load port.
- WD4  in  DATA_W  write data, load port.
- WE4  in  1  write enable, load port; also clears pending[A4].
- R15  in  DATA_W  current PC value.
- SB_SET  in  1  mark register SB_A pending (load issued).
- SB_A  in  ADDR_W  scoreboard set address.
- BUSY1  out  1  pending[A1].
- BUSY2  out  1  pending[A2].
- STALL  out  1  BUSY1 or BUSY2.
- COLLIDE  out  1  registered one-cycle pulse on a same-address dual write.

Behaviour:
- One clock domain. Reset is synchronous and active-high: on the clk edge with rst=1, all registers are cleared to 0, all pending bits to 0, and COLLIDE to 0. Write and scoreboard inputs are ignored in that cycle.
- Outputs after reset:
  - RD1/RD2 = 0, except a read of PC_REG, which returns R15+PC_OFFSET.
  - BUSY1/BUSY2/STALL = 0.
- Reads are combinational with zero latency: RDn = regs[An]. If An == PC_REG, RDn = (R15 + PC_OFFSET) modulo 2**DATA_W; carry out is discarded.
- An address at or above NREGS reads 0.
- Writes commit at the rising clk edge and are visible on RD the following cycle (see BYPASS_EN for the exception).
- Writes are ignored for:
  - address PC_REG (the PC is held externally), and
  - addresses at or above NREGS.
- Dual write, WE3 and WE4 with A3 == A4:
  - WD3 is stored and WD4 is dropped.
  - COLLIDE = 1 in the next cycle only.
  - pending[A4] is still cleared.
- Dual write to different addresses: both are committed in the same edge.
- Scoreboard, updated each edge:
  - SB_SET sets pending[SB_A].
  - WE4 clears pending[A4].
  - If SB_SET and WE4 target the same address in the same cycle, set wins (the new load supersedes).
  - SB_SET on PC_REG or on an out-of-range address is ignored.
  - WE3 never modifies pending.
- BUSY1 = pending[A1], BUSY2 = pending[A2], STALL = BUSY1 | BUSY2. All three are combinational on A1/A2 and registered pending state.
- A read of a pending register still returns its stale stored value; stalling is the consumer's responsibility.
- Reset asserted mid-operation: in-flight pending bits are lost, and any WE3/WE4 in the reset cycle is discarded.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-to-read forwarding in the same cycle.
  - If WE3 and A3 == An (n = 1, 2; An not PC_REG, in range), RDn = WD3.
  - Otherwise, if WE4 and A4 == An, RDn = WD4.
  - Port 3 has priority, consistent with the collision rule.
  - BUSYn is forced to 0 when WE4 and A4 == An; a load completing this cycle must not stall its consumer.
- Undefined: no forwarding; reads see only committed state and BUSY reflects registered pending only.

Test Plan:
- Reset then read: rst=1 for one edge, A1=3, A2=15, R15=0x100 -> RD1=0x0, RD2=0x108, STALL=0.
- Basic write: WE3=1, A3=2, WD3=0x87654321 for one edge, then A1=2 -> RD1=0x87654321. With WE3=0 and A3=1, WD3=0x12345678 -> regs[1] stays 0.
- Dual write and collision: WE3=WE4=1, A3=A4=5, WD3=0xAAAA0000, WD4=0x5555FFFF -> next cycle RD1(A1=5)=0xAAAA0000, COLLIDE=1 for exactly one cycle. Different addresses (A3=6, A4=7) -> both written, COLLIDE=0.
- Scoreboard: SB_SET=1, SB_A=4, then A2=4 -> BUSY2=1, STALL=1. Then WE4=1, A4=4, WD4=0x77 -> next cycle BUSY2=0, RD2=0x77. SB_SET and WE4 both on reg 4 in the same cycle -> BUSY2 stays 1.
- PC handling: R15=0xFFFFFFFC, A1=15 -> RD1=0x00000004 (wrap). WE3=1, A3=15, WD3=0x1234 -> no effect. SB_SET with SB_A=15 -> BUSY1 stays 0.
- Bypass (REGFILE_BYPASS_EN): WE3=1, A3=9, WD3=0xDEAD, A1=9 -> RD1=0xDEAD in the same cycle. Without the macro, RD1 shows the old value until the next cycle.
